// File: rtl/prince_sbox_cms_compress.sv
// Two-stage CMS compression for one PRINCE S-box nibble: 8-share expanded bits are
// refreshed with a ring mask in stage A, then folded into two 4-bit shares in stage B.
module prince_sbox_cms_compress #(
    parameter bit RND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] sh_in,
    input  logic [31:0] rnd_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_sh0,
    output logic [3:0]  out_sh1,
    output logic [15:0] out_cnt
);

    logic        r_a_valid;
    logic [31:0] r_sh_a;
    logic        r_b_valid;
    logic [3:0]  r_sh0;
    logic [3:0]  r_sh1;
    logic [15:0] r_cnt;

    logic        w_b_adv;
    logic        w_a_adv;
    logic [31:0] w_sh_a;
    logic [3:0]  w_cmp0;
    logic [3:0]  w_cmp1;

    assign w_b_adv  = !r_b_valid || out_ready;
    assign w_a_adv  = !r_a_valid || w_b_adv;
    assign in_ready = w_a_adv && !clr;

    // Each mask bit enters two neighbouring shares of the same bit, so it cancels in the share sum.
    for (genvar b = 0; b < 4; b++) begin : g_bit
        for (genvar s = 0; s < 8; s++) begin : g_share
            if (RND_EN) begin : g_ref
                assign w_sh_a[b*8+s] = sh_in[b*8+s] ^ rnd_in[b*8+s] ^ rnd_in[b*8+((s+1)%8)];
            end else begin : g_byp
                assign w_sh_a[b*8+s] = sh_in[b*8+s];
            end
        end
        assign w_cmp0[b] = ^r_sh_a[b*8 +: 4];
        assign w_cmp1[b] = ^r_sh_a[b*8+4 +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_sh_a    <= '0;
        end else if (clr) begin
            r_a_valid <= 1'b0;
            r_sh_a    <= '0;
        end else if (w_a_adv) begin
            if (in_valid) begin
                r_a_valid <= 1'b1;
                r_sh_a    <= w_sh_a;
            end else begin
                r_a_valid <= 1'b0;
                r_sh_a    <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_sh0     <= '0;
            r_sh1     <= '0;
        end else if (clr) begin
            r_b_valid <= 1'b0;
            r_sh0     <= '0;
            r_sh1     <= '0;
        end else if (w_b_adv) begin
            if (r_a_valid) begin
                r_b_valid <= 1'b1;
                r_sh0     <= w_cmp0;
                r_sh1     <= w_cmp1;
            end else begin
                r_b_valid <= 1'b0;
                r_sh0     <= '0;
                r_sh1     <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_b_valid && out_ready) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign out_valid = r_b_valid;
    assign out_sh0   = r_sh0;
    assign out_sh1   = r_sh1;
    assign out_cnt   = r_cnt;

endmodule
